// File: rtl/register_bank_pkg.sv
// Shared opcode definitions for the register bank and its ALU.
// REGISTER_BANK_SHIFT_EN enables SHL/SHR; without it those opcodes behave as NOP.
package register_bank_pkg;

    typedef enum logic [2:0] {
        OP_NOP    = 3'd0,
        OP_LOAD   = 3'd1,
        OP_CLRONE = 3'd2,
        OP_INC    = 3'd3,
        OP_DEC    = 3'd4,
        OP_SHL    = 3'd5,
        OP_SHR    = 3'd6,
        OP_COPY   = 3'd7
    } op_e;

    localparam logic [2:0] OPC_NOP    = 3'd0;
    localparam logic [2:0] OPC_LOAD   = 3'd1;
    localparam logic [2:0] OPC_CLRONE = 3'd2;
    localparam logic [2:0] OPC_INC    = 3'd3;
    localparam logic [2:0] OPC_DEC    = 3'd4;
    localparam logic [2:0] OPC_SHL    = 3'd5;
    localparam logic [2:0] OPC_SHR    = 3'd6;
    localparam logic [2:0] OPC_COPY   = 3'd7;

endpackage

// File: rtl/register_bank_alu.sv
// Combinational result/carry for one register-bank operation.
// Shift ops exist only when REGISTER_BANK_SHIFT_EN is defined.
module register_bank_alu
    import register_bank_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] operand,
    input  logic [WIDTH-1:0] din,
    input  logic             sin,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             wr
);

    logic [WIDTH:0] sum;

    assign sum = {1'b0, operand} + (WIDTH+1)'(1);

`ifndef REGISTER_BANK_SHIFT_EN
    logic unused_sin;
    assign unused_sin = sin;
`endif

    always_comb begin
        result = operand;
        carry  = 1'b0;
        wr     = 1'b1;
        case (op_e'(op))
            OP_LOAD:   result = din;
            OP_CLRONE: result = '0;
            OP_INC: begin
                result = sum[WIDTH-1:0];
                carry  = sum[WIDTH];
            end
            OP_DEC: begin
                result = operand - WIDTH'(1);
                carry  = (operand == '0);
            end
`ifdef REGISTER_BANK_SHIFT_EN
            OP_SHL: begin
                result = {operand[WIDTH-2:0], sin};
                carry  = operand[WIDTH-1];
            end
            OP_SHR: begin
                result = {sin, operand[WIDTH-1:1]};
                carry  = operand[0];
            end
`endif
            // COPY: the top already routed reg[RADDR] onto operand.
            OP_COPY:   result = operand;
            default:   wr = 1'b0;
        endcase
    end

endmodule

// File: rtl/register_bank.sv
// Small register file with per-cycle ALU ops, carry/zero flags, clear and reset.
// Optional shift ops are controlled by REGISTER_BANK_SHIFT_EN.
module register_bank
    import register_bank_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     CLR,
    input  logic [2:0]               OP,
    input  logic [$clog2(DEPTH)-1:0] WADDR,
    input  logic [$clog2(DEPTH)-1:0] RADDR,
    input  logic [WIDTH-1:0]         DIN,
    input  logic                     SIN,
    output logic [WIDTH-1:0]         DOUT,
    output logic                     CARRY,
    output logic                     ZERO
);

    logic [WIDTH-1:0] regs [DEPTH];
    logic [WIDTH-1:0] operand;
    logic [WIDTH-1:0] result;
    logic             alu_carry;
    logic             alu_wr;

    // COPY sources from the read port; every other op works on the target.
    assign operand = (OP == OPC_COPY) ? regs[RADDR] : regs[WADDR];
    assign DOUT    = regs[RADDR];

    register_bank_alu #(.WIDTH(WIDTH)) u_alu (
        .op      (OP),
        .operand (operand),
        .din     (DIN),
        .sin     (SIN),
        .result  (result),
        .carry   (alu_carry),
        .wr      (alu_wr)
    );

    always_ff @(posedge CLK) begin
        if (RESET || CLR) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
            CARRY <= 1'b0;
            ZERO  <= 1'b1;
        end else if (alu_wr) begin
            regs[WADDR] <= result;
            CARRY       <= alu_carry;
            ZERO        <= (result == '0);
        end
    end

endmodule

// File: tb/tb_register_bank.sv
// Directed bench for register_bank: reference model plus hand-computed literal checks.
module tb_register_bank;

    localparam int W = 8;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         clr = 1'b0;
    logic [2:0]   op = 3'd0;
    logic [1:0]   waddr = 2'd0;
    logic [1:0]   raddr = 2'd0;
    logic [W-1:0] din = '0;
    logic         sin = 1'b0;
    logic [W-1:0] dout;
    logic         carry;
    logic         zero;

    int checks = 0;
    int errors = 0;

    register_bank #(.WIDTH(W), .DEPTH(D)) dut (
        .CLK(clk), .RESET(rst), .CLR(clr), .OP(op), .WADDR(waddr), .RADDR(raddr),
        .DIN(din), .SIN(sin), .DOUT(dout), .CARRY(carry), .ZERO(zero)
    );

    always #10 clk = ~clk;

    // Reference model: array of integers updated from the op semantics.
    int  m_regs [D];
    bit  m_carry;
    bit  m_zero;
    bit  model_ok = 1'b0;

    always @(posedge clk) begin
        int  res;
        bit  c;
        bit  wr;
        if (rst || clr) begin
            for (int i = 0; i < D; i++) m_regs[i] = 0;
            m_carry = 0;
            m_zero  = 1;
            if (rst) model_ok = 1'b1;
        end else begin
            res = m_regs[waddr];
            c   = 0;
            wr  = 1;
            case (op)
                3'd1: res = din;
                3'd2: res = 0;
                3'd3: begin res = (m_regs[waddr] + 1) % 256; c = (m_regs[waddr] == 255); end
                3'd4: begin res = (m_regs[waddr] + 255) % 256; c = (m_regs[waddr] == 0); end
`ifdef REGISTER_BANK_SHIFT_EN
                3'd5: begin res = (m_regs[waddr] * 2) % 256 + sin; c = (m_regs[waddr] >= 128); end
                3'd6: begin res = m_regs[waddr] / 2 + (sin ? 128 : 0); c = (m_regs[waddr] % 2 == 1); end
`endif
                3'd7: res = m_regs[raddr];
                default: wr = 0;
            endcase
            if (wr) begin
                m_regs[waddr] = res;
                m_carry = c;
                m_zero  = (res == 0);
            end
        end
    end

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (model_ok) begin
            check("model_dout", dout, W'(m_regs[raddr]));
            check("model_carry", {7'd0, carry}, {7'd0, m_carry});
            check("model_zero", {7'd0, zero}, {7'd0, m_zero});
        end
    end

    task automatic set_in(input logic [2:0] o, input logic [1:0] wa, input logic [1:0] ra,
                          input logic [W-1:0] d, input logic s, input logic c, input logic r);
        op = o; waddr = wa; raddr = ra; din = d; sin = s; clr = c; rst = r;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_op(input logic [2:0] o, input logic [1:0] wa, input logic [1:0] ra,
                         input logic [W-1:0] d, input logic s, input logic c, input logic r);
        set_in(o, wa, ra, d, s, c, r);
        tick();
        set_in(3'd0, wa, ra, '0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic peek(input string name, input logic [1:0] ra, input logic [W-1:0] exp);
        raddr = ra;
        #1;
        check(name, dout, exp);
    endtask

    task automatic flags(input string name, input logic c, input logic z);
        check({name, "_carry"}, {7'd0, carry}, {7'd0, c});
        check({name, "_zero"}, {7'd0, zero}, {7'd0, z});
    endtask

    initial begin
        // Reset state
        do_op(3'd0, 2'd0, 2'd0, '0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < D; i++) peek("reset_dout", 2'(i), 8'h00);
        flags("reset", 1'b0, 1'b1);

        // INC wrap, NOP hold, DEC borrow
        do_op(3'd1, 2'd2, 2'd2, 8'hFF, 1'b0, 1'b0, 1'b0);
        do_op(3'd3, 2'd2, 2'd2, '0, 1'b0, 1'b0, 1'b0);
        peek("inc_wrap", 2'd2, 8'h00);
        flags("inc_wrap", 1'b1, 1'b1);
        do_op(3'd0, 2'd2, 2'd2, 8'h55, 1'b1, 1'b0, 1'b0);
        peek("nop_hold", 2'd2, 8'h00);
        flags("nop_hold", 1'b1, 1'b1);
        do_op(3'd4, 2'd2, 2'd2, '0, 1'b0, 1'b0, 1'b0);
        peek("dec_borrow", 2'd2, 8'hFF);
        flags("dec_borrow", 1'b1, 1'b0);
        do_op(3'd4, 2'd2, 2'd2, '0, 1'b0, 1'b0, 1'b0);
        peek("dec_plain", 2'd2, 8'hFE);
        flags("dec_plain", 1'b0, 1'b0);

        // Shifts
        do_op(3'd1, 2'd1, 2'd1, 8'h81, 1'b0, 1'b0, 1'b0);
        do_op(3'd5, 2'd1, 2'd1, '0, 1'b0, 1'b0, 1'b0);
`ifdef REGISTER_BANK_SHIFT_EN
        peek("shl", 2'd1, 8'h02);
        flags("shl", 1'b1, 1'b0);
`else
        peek("shl_off", 2'd1, 8'h81);
        flags("shl_off", 1'b0, 1'b0);
`endif
        do_op(3'd6, 2'd1, 2'd1, '0, 1'b1, 1'b0, 1'b0);
        peek("shr", 2'd1, 8'h81);
        flags("shr", 1'b0, 1'b0);

        // COPY, then read-during-write on r3
        do_op(3'd1, 2'd0, 2'd0, 8'h5A, 1'b0, 1'b0, 1'b0);
        do_op(3'd7, 2'd3, 2'd0, '0, 1'b0, 1'b0, 1'b0);
        peek("copy_dst", 2'd3, 8'h5A);
        peek("copy_src", 2'd0, 8'h5A);
        flags("copy", 1'b0, 1'b0);
        set_in(3'd1, 2'd3, 2'd3, 8'h33, 1'b0, 1'b0, 1'b0);
        #1;
        check("rdw_old", dout, 8'h5A);
        tick();
        set_in(3'd0, 2'd3, 2'd3, '0, 1'b0, 1'b0, 1'b0);
        peek("rdw_new", 2'd3, 8'h33);

        // Self-copy keeps value but refreshes flags
        do_op(3'd1, 2'd1, 2'd1, 8'h00, 1'b0, 1'b0, 1'b0);
        do_op(3'd7, 2'd2, 2'd2, '0, 1'b0, 1'b0, 1'b0);
        peek("selfcopy", 2'd2, 8'hFE);
        flags("selfcopy", 1'b0, 1'b0);

        // CLR overrides LOAD
        do_op(3'd1, 2'd1, 2'd1, 8'h10, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < D; i++) peek("clr_dout", 2'(i), 8'h00);
        flags("clr", 1'b0, 1'b1);

        // RESET discards a concurrent INC
        do_op(3'd1, 2'd1, 2'd1, 8'h07, 1'b0, 1'b0, 1'b0);
        do_op(3'd1, 2'd0, 2'd0, 8'hFF, 1'b0, 1'b0, 1'b0);
        do_op(3'd3, 2'd0, 2'd0, '0, 1'b0, 1'b0, 1'b0);
        flags("pre_reset", 1'b1, 1'b1);
        do_op(3'd3, 2'd1, 2'd1, '0, 1'b0, 1'b0, 1'b1);
        peek("reset_inc", 2'd1, 8'h00);
        flags("reset_inc", 1'b0, 1'b1);

        // Sweep every opcode across every register for the model compare
        for (int o = 0; o < 8; o++) begin
            for (int a = 0; a < D; a++) begin
                do_op(3'(o), 2'(a), 2'(D - 1 - a), 8'(8'h3C + 17 * a), 1'(a % 2), 1'b0, 1'b0);
            end
        end

        tick();
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
